vga_sync_pulses: RTL and testbench
==================================

# vga_sync_pulses

Free-running VGA timing generator for the 640x480@60 Hz pipeline. Sits directly upstream of the porch stage: it produces the raw active-area Hsync/Vsync pulses (high while inside the active columns/rows), the aligned column/row position, and line/frame strobes for the game logic. Porch shaping and final colour alignment are done downstream.

## Interface
Parameters:
- TOTAL_COLS, 800, pixels per line including blanking
- TOTAL_ROWS, 525, lines per frame including blanking
- ACTIVE_COLS, 640, visible pixels per line
- ACTIVE_ROWS, 480, visible lines per frame

Ports:
- clock  input  1  pixel clock, all logic on rising edge
- reset  input  1  asynchronous, active-high reset
- enable  input  1  count enable; low freezes timing
- out_Hsync  output  1  high while registered column < ACTIVE_COLS
- out_Vsync  output  1  high while registered row < ACTIVE_ROWS
- column  output  10  column position aligned with the syncs
- row  output  10  row position aligned with the syncs
- active  output  1  out_Hsync AND out_Vsync, registered
- line_start  output  1  one-cycle strobe when column == 0
- frame_start  output  1  one-cycle strobe when column == 0 and row == 0
- frame_count  output  8  completed-frame counter (see Configuration)

## Operation
- Internal counters col_cnt and row_cnt, 10 bits each; both reset to 0.
- Each rising edge with enable=1:
  - col_cnt increments; at TOTAL_COLS-1 wraps to 0.
  - row_cnt increments only on the edge where col_cnt wraps; at TOTAL_ROWS-1 (with col wrap) wraps to 0.
  - Output registers load from the pre-increment counter values: column <= col_cnt, row <= row_cnt, out_Hsync <= (col_cnt < ACTIVE_COLS), out_Vsync <= (row_cnt < ACTIVE_ROWS), active <= both, line_start <= (col_cnt == 0), frame_start <= (col_cnt == 0 && row_cnt == 0).
- enable=0: counters and all output registers hold. Strobes that were high stay high for the whole hold. Downstream stages run enable tied high, so this case is bench/debug only.
- Comparisons are unsigned 10-bit. Parameters must satisfy ACTIVE < TOTAL <= 1024.
- No state machine beyond the two wrap counters. The counter pair is the state: 800x525 = 420000 states per frame.

## Timing
- Reset (asynchronous assert, any time including mid-frame): col_cnt, row_cnt, column, row, frame_count = 0. out_Hsync, out_Vsync, active, line_start, frame_start = 0.
- Reset release is synchronous to the first rising edge that sees reset low.
- First enabled edge after reset produces out_Hsync=1, out_Vsync=1, active=1, line_start=1, frame_start=1, column=0, row=0.
- Latency: outputs lag the internal counters by exactly 1 cycle. column/row and both syncs always describe the same pixel.
- Periods with enable held high:
  - out_Hsync: high 640 cycles, low 160, period 800.
  - out_Vsync: high 480*800 = 384000 cycles, low 45*800 = 36000, period 420000.
  - line_start: every 800 cycles.
  - frame_start: every 420000 cycles.
- Simultaneous column and row wrap (col 799, row 524): the next edge yields column=0, row=0, frame_start=1.

## Configuration
- Macro VGA_FRAME_COUNT_EN.
- Defined: frame_count increments by 1 (mod 256) on each edge where frame_start is loaded as 1, excluding the first frame after reset. frame_count therefore reads 1 at the second frame_start.
- Undefined: frame_count is constant 0 and no counter register is built.
- All other behaviour is identical in both builds.

## Test plan
- Reset, release, enable=1 -> first edge gives column=0, row=0, out_Hsync=1, out_Vsync=1, frame_start=1. Cycle 640 after that edge gives out_Hsync=0, column=640.
- Run one full line -> out_Hsync high for exactly 640 cycles, low for 160. line_start pulses at cycles 0 and 800. Column sequence is 0..799 then 0.
- Run 2 full frames -> frame_start pulses exactly at cycles 0 and 420000. out_Vsync falls at cycle 384000 with row=480. row=524, column=799 is followed by row=0, column=0.
- Drop enable for 100 cycles at column 300, row 10 -> all outputs hold column=300, row=10. Counting resumes with column=301 on the first re-enabled edge.
- Assert reset asynchronously mid-frame at column 500, row 200 -> all outputs read 0 before the next edge. After release the sequence restarts exactly as in the first scenario.
- With VGA_FRAME_COUNT_EN, run 257 frames -> frame_count reads 1 after the 2nd frame_start and wraps to 0 at the 257th. Without the macro -> frame_count stays 0 throughout.

Source files
------------

// File: rtl/vga_sync_pulses.sv
`default_nettype none
// ============================================================================
// Module   : vga_sync_pulses
// Purpose  : Free-running VGA timing generator (640x480@60 Hz by default).
//            Two wrap counters (column, row) are the only state; every output
//            is registered from the pre-increment counter values, so all
//            outputs lag the counters by one cycle and describe one pixel.
// Ports    : clock        - pixel clock, rising edge
//            reset        - asynchronous active-high reset
//            enable       - count enable; low freezes counters and outputs
//            out_Hsync    - high while column < ACTIVE_COLS
//            out_Vsync    - high while row < ACTIVE_ROWS
//            column, row  - pixel position aligned with the syncs
//            active       - out_Hsync AND out_Vsync
//            line_start   - strobe for column 0
//            frame_start  - strobe for column 0, row 0
//            frame_count  - completed-frame counter (mod 256)
// Options  : VGA_FRAME_COUNT_EN - builds the frame counter; when undefined
//            frame_count is tied to 0.
// Revision : 1.0 - initial release
// ============================================================================
module vga_sync_pulses #(
  parameter int unsigned TOTAL_COLS  = 800,
  parameter int unsigned TOTAL_ROWS  = 525,
  parameter int unsigned ACTIVE_COLS = 640,
  parameter int unsigned ACTIVE_ROWS = 480
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  output logic       out_Hsync,
  output logic       out_Vsync,
  output logic [9:0] column,
  output logic [9:0] row,
  output logic       active,
  output logic       line_start,
  output logic       frame_start,
  output logic [7:0] frame_count
);

  localparam logic [9:0] C_LAST_COL    = 10'(TOTAL_COLS - 1);
  localparam logic [9:0] C_LAST_ROW    = 10'(TOTAL_ROWS - 1);
  localparam logic [9:0] C_ACTIVE_COLS = 10'(ACTIVE_COLS);
  localparam logic [9:0] C_ACTIVE_ROWS = 10'(ACTIVE_ROWS);

  logic [9:0] col_cnt_q, col_cnt_d;
  logic [9:0] row_cnt_q, row_cnt_d;
  logic       w_col_wrap;
  logic       w_at_origin;

  logic [9:0] column_q, row_q;
  logic       hsync_q, vsync_q, active_q, line_start_q, frame_start_q;

  assign w_col_wrap  = (col_cnt_q == C_LAST_COL);
  assign w_at_origin = (col_cnt_q == 10'd0) && (row_cnt_q == 10'd0);

  // Row advances only on the column wrap; both wrap together at the frame end.
  always_comb begin
    col_cnt_d = col_cnt_q + 10'd1;
    row_cnt_d = row_cnt_q;
    if (w_col_wrap) begin
      col_cnt_d = 10'd0;
      row_cnt_d = (row_cnt_q == C_LAST_ROW) ? 10'd0 : row_cnt_q + 10'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      col_cnt_q     <= 10'd0;
      row_cnt_q     <= 10'd0;
      column_q      <= 10'd0;
      row_q         <= 10'd0;
      hsync_q       <= 1'b0;
      vsync_q       <= 1'b0;
      active_q      <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else if (enable) begin
      col_cnt_q     <= col_cnt_d;
      row_cnt_q     <= row_cnt_d;
      // Outputs load from the pre-increment counters (one-cycle lag).
      column_q      <= col_cnt_q;
      row_q         <= row_cnt_q;
      hsync_q       <= (col_cnt_q < C_ACTIVE_COLS);
      vsync_q       <= (row_cnt_q < C_ACTIVE_ROWS);
      active_q      <= (col_cnt_q < C_ACTIVE_COLS) && (row_cnt_q < C_ACTIVE_ROWS);
      line_start_q  <= (col_cnt_q == 10'd0);
      frame_start_q <= w_at_origin;
    end
  end

  assign out_Hsync   = hsync_q;
  assign out_Vsync   = vsync_q;
  assign column      = column_q;
  assign row         = row_q;
  assign active      = active_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

`ifdef VGA_FRAME_COUNT_EN
  logic [7:0] frame_cnt_q;
  logic       seen_frame_q;

  // The first frame_start after reset only arms the counter; each later one
  // marks the completion of a frame.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      frame_cnt_q  <= 8'd0;
      seen_frame_q <= 1'b0;
    end else if (enable && w_at_origin) begin
      if (seen_frame_q) begin
        frame_cnt_q <= frame_cnt_q + 8'd1;
      end
      seen_frame_q <= 1'b1;
    end
  end

  assign frame_count = frame_cnt_q;
`else
  assign frame_count = 8'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vga_sync_pulses.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_sync_pulses
// Purpose  : Self-checking bench for vga_sync_pulses using reduced timing
//            parameters. The reference model maps the number of enabled
//            edges since reset onto a pixel index and derives every output
//            from it arithmetically.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_sync_pulses;

  localparam int unsigned TC    = 16;
  localparam int unsigned TR    = 10;
  localparam int unsigned AC    = 12;
  localparam int unsigned AR    = 7;
  localparam int unsigned FRAME = TC * TR;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic       out_Hsync, out_Vsync, active, line_start, frame_start;
  logic [9:0] column, row;
  logic [7:0] frame_count;

  int unsigned n = 0;       // enabled edges since reset release
  int          checks = 0;
  int          errors = 0;

  logic [32:0] obs;
  assign obs = {out_Hsync, out_Vsync, active, line_start, frame_start,
                column, row, frame_count};

  vga_sync_pulses #(
    .TOTAL_COLS (TC),
    .TOTAL_ROWS (TR),
    .ACTIVE_COLS(AC),
    .ACTIVE_ROWS(AR)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .out_Hsync  (out_Hsync),
    .out_Vsync  (out_Vsync),
    .column     (column),
    .row        (row),
    .active     (active),
    .line_start (line_start),
    .frame_start(frame_start),
    .frame_count(frame_count)
  );

  always #5 clock = ~clock;

  // Expected outputs after k enabled edges since reset.
  function automatic logic [32:0] model(input int unsigned k);
    int unsigned p, c, r, fc;
    logic hs, vs;
    if (k == 0) return 33'd0;
    p  = (k - 1) % FRAME;
    c  = p % TC;
    r  = p / TC;
`ifdef VGA_FRAME_COUNT_EN
    fc = ((k - 1) / FRAME) % 256;
`else
    fc = 0;
`endif
    hs = (c < AC);
    vs = (r < AR);
    return {hs, vs, hs & vs, (c == 0), (p == 0), 10'(c), 10'(r), 8'(fc)};
  endfunction

  // One clock edge; inputs change and outputs are sampled 1 ns after it.
  task automatic tick();
    @(posedge clock);
    if (enable && !reset) n++;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n = 0;
  endtask

  task automatic test_reset();
    enable = 1'b0;
    do_reset();
    checks++;
    if (obs !== 33'd0) begin
      errors++; $display("FAIL reset_state got %h want %h", obs, 33'd0);
    end
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (obs !== 33'd0) begin
      errors++; $display("FAIL reset_idle got %h want %h", obs, 33'd0);
    end
  endtask

  task automatic test_first_line();
    enable = 1'b1;
    for (int i = 0; i <= TC; i++) begin
      tick();
      checks++;
      if (obs !== model(n)) begin
        errors++; $display("FAIL first_line i=%0d got %h want %h", i, obs, model(n));
      end
      if (i == 0) begin
        checks++;
        if ({out_Hsync, out_Vsync, active, line_start, frame_start, column, row}
            !== {5'b11111, 10'd0, 10'd0}) begin
          errors++; $display("FAIL first_edge got %h", obs);
        end
      end
      if (i == AC) begin
        checks++;
        if ({out_Hsync, column} !== {1'b0, 10'(AC)}) begin
          errors++; $display("FAIL hsync_fall got hs=%b col=%0d want hs=0 col=%0d",
                             out_Hsync, column, AC);
        end
      end
    end
  endtask

  task automatic test_frames();
    int unsigned fs_seen = 0;
    enable = 1'b1;
    for (int i = 0; i < 2 * FRAME + 1; i++) begin
      tick();
      checks++;
      if (obs !== model(n)) begin
        errors++; $display("FAIL frames n=%0d got %h want %h", n, obs, model(n));
      end
      if (frame_start) fs_seen++;
    end
    checks++;
    if (fs_seen != 2) begin
      errors++; $display("FAIL frame_start_count got %0d want 2", fs_seen);
    end
  endtask

  task automatic test_enable_hold();
    int unsigned hold;
    int unsigned guard = 0;
    enable = 1'b1;
    while (!(column == 10'd5 && row == 10'd2) && guard < 2 * FRAME) begin
      tick();
      guard++;
    end
    checks++;
    if (guard >= 2 * FRAME) begin
      errors++; $display("FAIL hold_reach got col=%0d row=%0d want 5,2", column, row);
    end
    enable = 1'b0;
    hold = $urandom_range(20, 5);
    for (int i = 0; i < hold; i++) begin
      tick();
      checks++;
      if (obs !== model(n) || column !== 10'd5 || row !== 10'd2) begin
        errors++; $display("FAIL hold i=%0d got %h want %h", i, obs, model(n));
      end
    end
    enable = 1'b1;
    tick();
    checks++;
    if (column !== 10'd6 || obs !== model(n)) begin
      errors++; $display("FAIL resume got col=%0d want 6 (%h vs %h)", column, obs, model(n));
    end
  endtask

  task automatic test_random_enable();
    for (int i = 0; i < 2000; i++) begin
      enable = ($urandom_range(3, 0) != 0);
      tick();
      checks++;
      if (obs !== model(n)) begin
        errors++; $display("FAIL random_en n=%0d got %h want %h", n, obs, model(n));
      end
    end
    enable = 1'b1;
  endtask

  task automatic test_async_reset();
    int unsigned run;
    enable = 1'b1;
    run = $urandom_range(FRAME - 1, FRAME / 2);
    for (int i = 0; i < run; i++) tick();
    #2 reset = 1'b1;
    #1;
    checks++;
    if (obs !== 33'd0) begin
      errors++; $display("FAIL async_reset got %h want %h", obs, 33'd0);
    end
    tick();
    reset = 1'b0;
    n = 0;
    for (int i = 0; i <= TC; i++) begin
      tick();
      checks++;
      if (obs !== model(n)) begin
        errors++; $display("FAIL restart i=%0d got %h want %h", i, obs, model(n));
      end
    end
  endtask

  task automatic test_frame_count();
    logic [7:0] want2, want257;
`ifdef VGA_FRAME_COUNT_EN
    want2 = 8'd1; want257 = 8'd0;
`else
    want2 = 8'd0; want257 = 8'd0;
`endif
    enable = 1'b0;
    do_reset();
    enable = 1'b1;
    for (int i = 0; i < 256 * FRAME + 1; i++) begin
      tick();
      if (frame_start || (n % 37) == 0) begin
        checks++;
        if (obs !== model(n)) begin
          errors++; $display("FAIL frame_count_run n=%0d got %h want %h", n, obs, model(n));
        end
      end
      if (n == FRAME + 1) begin
        checks++;
        if (frame_count !== want2) begin
          errors++; $display("FAIL fc_second got %0d want %0d", frame_count, want2);
        end
      end
    end
    checks++;
    if (frame_count !== want257 || frame_start !== 1'b1) begin
      errors++; $display("FAIL fc_wrap got fc=%0d fs=%b want fc=%0d fs=1",
                         frame_count, frame_start, want257);
    end
  endtask

  initial begin
    test_reset();
    test_first_line();
    test_frames();
    test_enable_hold();
    test_random_enable();
    test_async_reset();
    test_frame_count();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
